alu_cmd_sequencer: RTL and testbench

Command-side initiator for the 16-bit combinational ALU. It accepts register-based operation commands over a valid/ready handshake, reads operands from an 8×16 register file, drives the ALU's A/B/Sel inputs, captures Y/cout/zero, writes the result back, and returns a response over a second valid/ready handshake. It sits between the instruction/command source and the ALU and is the only block that drives the ALU inputs.

---
 rtl/alu_cmd_sequencer.sv | 138 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: accepts register-based ALU commands, reads operands from
// an 8 x 16 register file, drives the external combinational ALU for one
// cycle, captures its result and flags, writes the result back and returns
// it on a valid/ready response channel. Three-state control: IDLE/EXEC/RESP.
module alu_cmd_sequencer #(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,

  // command channel
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [AW-1:0]     cmd_rd,
  input  logic [AW-1:0]     cmd_ra,
  input  logic [AW-1:0]     cmd_rb,
  input  logic              cmd_imm_en,
  input  logic [DATA_W-1:0] cmd_imm,

  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_cout,
  input  logic              alu_zero,

  // response channel
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [AW-1:0]     rsp_rd,
  output logic              rsp_cout,
  output logic              rsp_zero,

  // sticky flags of the last completed operation
  output logic              flag_c,
  output logic              flag_z
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] rf [NREG];
  logic [AW-1:0]     rd_q;
  logic              accept;

  // Register 0 reads as zero regardless of what the array holds.
  function automatic logic [DATA_W-1:0] rf_read(input logic [AW-1:0] idx);
    return (idx == '0) ? '0 : rf[idx];
  endfunction

  // Ready only in IDLE and never while reset is being applied.
  assign cmd_ready = (state_q == IDLE) && rst_n;
  assign accept    = cmd_valid && cmd_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  // NOTE: every signal written here is defaulted first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on command acceptance; ALU operands then hold until the
  // next accepted command.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      rd_q    <= '0;
    end else if (accept) begin
      alu_a   <= rf_read(cmd_ra);
      alu_b   <= cmd_imm_en ? cmd_imm : rf_read(cmd_rb);
      alu_sel <= cmd_op;
      rd_q    <= cmd_rd;
    end
  end

  // Result capture at the end of EXEC; fields then hold through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_rd   <= '0;
      rsp_cout <= 1'b0;
      rsp_zero <= 1'b0;
      flag_c   <= 1'b0;
      flag_z   <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_data <= alu_y;
      rsp_rd   <= rd_q;
      rsp_cout <= alu_cout;
      rsp_zero <= alu_zero;
      flag_c   <= alu_cout;
      flag_z   <= alu_zero;
    end
  end

  // Register-file writeback at the end of EXEC, so the value is visible in
  // RESP and to any command accepted afterwards; writes to r0 are dropped.
  // NOTE: the register file is small and architecturally defined to clear on
  // reset, so it is built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (state_q == EXEC && rd_q != '0) begin
      rf[rd_q] <= alu_y;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small behavioural ALU.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
  logic        cmd_imm_en;
  logic [15:0] cmd_imm;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_y;
  logic        alu_cout, alu_zero;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_rd;
  logic        rsp_cout, rsp_zero;
  logic        flag_c, flag_z;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_cout(rsp_cout), .rsp_zero(rsp_zero),
    .flag_c(flag_c), .flag_z(flag_z)
  );

  // Behavioural ALU: ADD, SUB (cout = borrow), AND, unsigned SLT; rest give 0.
  always_comb begin
    logic [16:0] t;
    t        = '0;
    alu_cout = 1'b0;
    case (alu_sel)
      4'b0000: begin t = {1'b0, alu_a} + {1'b0, alu_b}; alu_cout = t[16]; end
      4'b0001: begin t = {1'b0, alu_a} - {1'b0, alu_b}; alu_cout = (alu_a < alu_b); end
      4'b0100: t = {1'b0, alu_a & alu_b};
      4'b1101: t = {16'd0, alu_a < alu_b};
      default: t = '0;
    endcase
    alu_y    = t[15:0];
    alu_zero = (alu_y == 16'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full command: handshake, EXEC, RESP (optionally stalled), return to IDLE.
  // Entered just after a falling edge with the DUT in IDLE.
  task automatic do_cmd(input string tag, input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] ra, input logic [2:0] rb, input logic imm_en,
                        input logic [15:0] imm, input logic [15:0] ea, input logic [15:0] eb,
                        input logic [15:0] ey, input logic ec, input logic ez,
                        input int stall);
    check({tag, ".cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_imm_en = imm_en; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, ".alu_a"},   alu_a, ea);
    check({tag, ".alu_b"},   alu_b, eb);
    check({tag, ".alu_sel"}, alu_sel, op);
    check({tag, ".exec_ready"}, cmd_ready, 0);
    check({tag, ".exec_rsp_valid"}, rsp_valid, 0);
    @(negedge clk);
    check({tag, ".rsp_valid"}, rsp_valid, 1);
    check({tag, ".rsp_data"},  rsp_data, ey);
    check({tag, ".rsp_rd"},    rsp_rd, rd);
    check({tag, ".rsp_cout"},  rsp_cout, ec);
    check({tag, ".rsp_zero"},  rsp_zero, ez);
    check({tag, ".flag_c"},    flag_c, ec);
    check({tag, ".flag_z"},    flag_z, ez);
    for (int s = 0; s < stall; s++) begin
      // Hammer the command port while the response is blocked.
      cmd_valid  = s[0] ? 1'b0 : 1'b1;
      cmd_op     = 4'(s);
      cmd_rd     = 3'd6;
      cmd_ra     = 3'(s);
      cmd_imm_en = 1'b1;
      cmd_imm    = 16'hA5A0 + 16'(s);
      @(negedge clk);
      check({tag, ".stall_valid"}, rsp_valid, 1);
      check({tag, ".stall_data"},  rsp_data, ey);
      check({tag, ".stall_rd"},    rsp_rd, rd);
      check({tag, ".stall_cout"},  rsp_cout, ec);
      check({tag, ".stall_zero"},  rsp_zero, ez);
      check({tag, ".stall_ready"}, cmd_ready, 0);
      check({tag, ".stall_alu_a"}, alu_a, ea);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".done_rsp_valid"}, rsp_valid, 0);
    check({tag, ".done_ready"},     cmd_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0;
    cmd_rb = '0; cmd_imm_en = 1'b0; cmd_imm = '0; rsp_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.cmd_ready", cmd_ready, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.alu_a", alu_a, 0);
    check("rst.alu_b", alu_b, 0);
    check("rst.alu_sel", alu_sel, 0);
    check("rst.flags", {flag_c, flag_z}, 0);
    rst_n = 1'b1;
    #1 check("rst.release_ready", cmd_ready, 1);

    //      tag     op       rd    ra    rb    ie  imm       a         b         y         c  z  stall
    do_cmd("add1", 4'b0000, 3'd1, 3'd0, 3'd0, 1, 16'h00FF, 16'h0000, 16'h00FF, 16'h00FF, 0, 0, 0);
    do_cmd("add2", 4'b0000, 3'd2, 3'd1, 3'd0, 1, 16'hFF01, 16'h00FF, 16'hFF01, 16'h0000, 1, 1, 0);
    do_cmd("and3", 4'b0100, 3'd3, 3'd2, 3'd1, 0, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 0, 1, 0);
    do_cmd("sub4", 4'b0001, 3'd4, 3'd0, 3'd0, 1, 16'h0001, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0);
    do_cmd("slt5", 4'b1101, 3'd5, 3'd1, 3'd4, 0, 16'h0000, 16'h00FF, 16'hFFFF, 16'h0001, 0, 0, 0);
    do_cmd("wr_r0", 4'b0000, 3'd0, 3'd1, 3'd0, 1, 16'h0001, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0);
    do_cmd("rd_r0", 4'b0000, 3'd6, 3'd0, 3'd0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);
    // Backpressure; stalled commands target r6 and must not land.
    do_cmd("bp", 4'b0000, 3'd6, 3'd5, 3'd0, 1, 16'h0010, 16'h0001, 16'h0010, 16'h0011, 0, 0, 5);

    // Flags and ALU operands persist across idle cycles.
    repeat (3) @(negedge clk);
    check("idle.flags", {flag_c, flag_z}, 2'b00);
    check("idle.alu_b", alu_b, 16'h0010);
    check("idle.ready", cmd_ready, 1);

    // r6 still holds 0x0011 (no writes from ignored commands); result into r7.
    do_cmd("chk_r6", 4'b0000, 3'd7, 3'd6, 3'd0, 1, 16'h0000, 16'h0011, 16'h0000, 16'h0011, 0, 0, 0);

    // Reset landing on the EXEC edge.
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_rd = 3'd7; cmd_ra = 3'd1;
    cmd_imm_en = 1'b1; cmd_imm = 16'h1234;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("abort.exec_b", alu_b, 16'h1234);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort.rsp_valid", rsp_valid, 0);
    check("abort.cmd_ready", cmd_ready, 0);
    check("abort.alu", {alu_a, alu_b, 12'd0, alu_sel}, 0);
    check("abort.rsp_data", rsp_data, 0);
    check("abort.rsp_rd", rsp_rd, 0);
    check("abort.rsp_flags", {rsp_cout, rsp_zero}, 0);
    check("abort.flags", {flag_c, flag_z}, 0);
    rst_n = 1'b1;
    #1 check("abort.ready_after", cmd_ready, 1);
    check("abort.rsp_valid_after", rsp_valid, 0);
    // r7 and r1 were cleared by reset.
    do_cmd("r7_cleared", 4'b0000, 3'd2, 3'd7, 3'd0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);
    do_cmd("r1_cleared", 4'b0000, 3'd2, 3'd1, 3'd0, 1, 16'h0005, 16'h0000, 16'h0005, 16'h0005, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
